// File: rtl/mriscv_pkg.sv
// rtl/mriscv_pkg.sv - shared core opcodes, interrupt FSM encoding and vector helper
package mriscv_pkg;

  localparam logic [11:0] OP_RETIRQ = 12'b001110011000;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ARMED   = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Vector address of a line: base plus id scaled by the per-vector stride.
  function automatic logic [31:0] irq_vec_addr(input logic [31:0] base,
                                               input logic [31:0] id,
                                               input int          shift);
    return base + (id << shift);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - redirect handshake between interrupt front-end and PC unit
interface irq_ctrl_if;

  logic        enable_int;
  logic [11:0] opcode;
  logic [31:0] pc_next;
  logic        irr;
  logic [31:0] irr_dest;
  logic [31:0] irr_ret;

  modport master (
    input  enable_int,
    input  opcode,
    input  pc_next,
    output irr,
    output irr_dest,
    output irr_ret
  );

  modport slave (
    output enable_int,
    output opcode,
    output pc_next,
    input  irr,
    input  irr_dest,
    input  irr_ret
  );

endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus previous-value flop, rising-edge pulse
module irq_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt front-end: edge capture, mask, fixed-priority pick,
// single-level redirect/return handshake with the PC unit
module irq_ctrl
  import mriscv_pkg::*;
#(
  parameter int          NIRQ      = 8,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 2,
  localparam int         IDW       = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  irq_ctrl_if.master      pc,
  output logic [IDW-1:0]  irq_id,
  output logic            in_service,
  output logic [NIRQ-1:0] pending
);

  logic [NIRQ-1:0] rise;

  genvar g;
  generate
    for (g = 0; g < NIRQ; g++) begin : g_line
      irq_sync_edge u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (irq_in[g]),
        .rise (rise[g])
      );
    end
  endgenerate

  irq_state_e      state_q, state_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic [31:0]     irr_dest_q, irr_dest_d;
  logic [31:0]     irr_ret_q, irr_ret_d;
  logic            irr_q, irr_d;
  logic            in_service_q, in_service_d;

  logic [NIRQ-1:0] cand;
  logic [NIRQ-1:0] clr;
  logic [IDW-1:0]  winner;
  logic            take;
  logic            retirq;

  assign cand   = pending_q & mask_q;
  assign take   = (state_q == IRQ_ARMED) && pc.enable_int;
  assign retirq = (state_q == IRQ_SERVICE) && pc.enable_int && (pc.opcode == OP_RETIRQ);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = IDW'(i);
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr[i] = take && (irq_id_q == IDW'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    irr_dest_d   = irr_dest_q;
    irr_ret_d    = irr_ret_q;
    irr_d        = irr_q;
    in_service_d = in_service_q;
    mask_d       = mask_we ? mask_wdata : mask_q;
    // A fresh rise beats the clear of the line being taken.
    pending_d    = (pending_q & ~clr) | rise;

    case (state_q)
      IRQ_IDLE: begin
        if (|cand) begin
          state_d    = IRQ_ARMED;
          irq_id_d   = winner;
          irr_dest_d = irq_vec_addr(VEC_BASE, 32'(winner), VEC_SHIFT);
          irr_d      = 1'b1;
        end
      end
      IRQ_ARMED: begin
        if (take) begin
          state_d      = IRQ_SERVICE;
          irr_ret_d    = pc.pc_next;
          irr_d        = 1'b0;
          in_service_d = 1'b1;
        end
      end
      IRQ_SERVICE: begin
        if (retirq) begin
          state_d      = IRQ_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IRQ_IDLE;
        irr_d        = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IRQ_IDLE;
      mask_q       <= '0;
      pending_q    <= '0;
      irq_id_q     <= '0;
      irr_dest_q   <= '0;
      irr_ret_q    <= '0;
      irr_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      irq_id_q     <= irq_id_d;
      irr_dest_q   <= irr_dest_d;
      irr_ret_q    <= irr_ret_d;
      irr_q        <= irr_d;
      in_service_q <= in_service_d;
    end
  end

  assign pc.irr      = irr_q;
  assign pc.irr_dest = irr_dest_q;
  assign pc.irr_ret  = irr_ret_q;
  assign irq_id      = irq_id_q;
  assign in_service  = in_service_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed bench for irq_ctrl with a cycle-level reference model
module tb_irq_ctrl;

  localparam logic [11:0] RETI = 12'b001110011000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic [2:0] irq_id;
  logic       in_service;
  logic [7:0] pending;

  irq_ctrl_if pc_if ();

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b1;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pc         (pc_if),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: irq_in samples of the last three edges, pending/mask vectors,
  // and a phase number (0 idle, 1 waiting for the PC unit, 2 handler running).
  logic [7:0]  m_h0 = 0, m_h1 = 0, m_h2 = 0;
  logic [7:0]  m_pend = 0, m_mask = 0;
  logic [7:0]  m_set, m_clr, m_cand;
  int          m_phase = 0;
  int          m_id = 0;
  logic [31:0] m_dest = 0, m_ret = 0;
  bit          m_irr = 0, m_svc = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_h0 = 0; m_h1 = 0; m_h2 = 0; m_pend = 0; m_mask = 0;
      m_phase = 0; m_id = 0; m_dest = 0; m_ret = 0; m_irr = 0; m_svc = 0;
    end else begin
      m_set  = m_h1 & ~m_h2;
      m_clr  = 8'h00;
      m_cand = m_pend & m_mask;
      if (m_phase == 0) begin
        if (m_cand != 0) begin
          for (int i = 0; i < 8; i++) begin
            if (m_cand[i]) begin
              m_id = i;
              break;
            end
          end
          m_dest  = 32'h100 + 32'(m_id * 4);
          m_irr   = 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (pc_if.enable_int) begin
          m_ret       = pc_if.pc_next;
          m_clr[m_id] = 1'b1;
          m_irr       = 0;
          m_svc       = 1;
          m_phase     = 2;
        end
      end else if (pc_if.enable_int && pc_if.opcode == RETI) begin
        m_svc   = 0;
        m_phase = 0;
      end
      m_pend = (m_pend & ~m_clr) | m_set;
      if (mask_we) m_mask = mask_wdata;
      m_h2 = m_h1;
      m_h1 = m_h0;
      m_h0 = irq_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_irr", 32'(pc_if.irr), 32'(m_irr));
      check("cmp_irr_dest", pc_if.irr_dest, m_dest);
      check("cmp_irr_ret", pc_if.irr_ret, m_ret);
      check("cmp_irq_id", 32'(irq_id), 32'(m_id));
      check("cmp_in_service", 32'(in_service), 32'(m_svc));
      check("cmp_pending", 32'(pending), 32'(m_pend));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_wdata = m;
    tick(1);
    mask_we = 1'b0;
  endtask

  task automatic enter(input logic [31:0] pc);
    pc_if.pc_next = pc;
    pc_if.enable_int = 1'b1;
    tick(1);
    pc_if.enable_int = 1'b0;
  endtask

  task automatic reti();
    pc_if.opcode = RETI;
    pc_if.enable_int = 1'b1;
    tick(1);
    pc_if.enable_int = 1'b0;
    pc_if.opcode = 12'h000;
  endtask

  initial begin
    pc_if.enable_int = 1'b0;
    pc_if.opcode = 12'h000;
    pc_if.pc_next = 32'h0;
    tick(3);
    check("rst_irr", 32'(pc_if.irr), 0);
    check("rst_in_service", 32'(in_service), 0);
    check("rst_pending", 32'(pending), 0);
    rstn = 1'b1;

    // Single line, latency and entry
    wr_mask(8'h01);
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(2);
    check("lat_e2_irr", 32'(pc_if.irr), 0);
    check("lat_e2_pending", 32'(pending), 32'h01);
    tick(1);
    check("lat_e3_irr", 32'(pc_if.irr), 1);
    check("single_dest", pc_if.irr_dest, 32'h100);
    enter(32'h2000);
    check("single_ret", pc_if.irr_ret, 32'h2000);
    check("single_svc", 32'(in_service), 1);
    check("single_irr_low", 32'(pc_if.irr), 0);
    reti();
    check("single_svc_done", 32'(in_service), 0);

    // Priority between simultaneous rises
    wr_mask(8'hFF);
    irq_in = 8'h24;
    tick(1);
    irq_in = 8'h00;
    tick(3);
    check("prio_id_first", 32'(irq_id), 2);
    check("prio_dest_first", pc_if.irr_dest, 32'h108);
    enter(32'h3000);
    reti();
    tick(1);
    check("prio_id_second", 32'(irq_id), 5);
    check("prio_dest_second", pc_if.irr_dest, 32'h114);
    check("prio_irr_second", 32'(pc_if.irr), 1);
    enter(32'h4000);
    reti();
    check("ret_ret_stable", pc_if.irr_ret, 32'h4000);

    // RETIRQ outside service is ignored
    reti();
    check("idle_reti_svc", 32'(in_service), 0);
    check("idle_reti_irr", 32'(pc_if.irr), 0);
    check("idle_reti_ret", pc_if.irr_ret, 32'h4000);
    check("idle_hold_id", 32'(irq_id), 5);

    // Masked request waits in pending, taken once unmasked
    wr_mask(8'h00);
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    tick(4);
    check("mask_pending", 32'(pending), 32'h08);
    check("mask_irr_off", 32'(pc_if.irr), 0);
    wr_mask(8'h08);
    check("mask_old_used", 32'(pc_if.irr), 0);
    tick(1);
    check("mask_irr_on", 32'(pc_if.irr), 1);
    check("mask_dest", pc_if.irr_dest, 32'h10C);
    enter(32'h5000);
    reti();

    // Re-rise of line 1 on the edge its pending bit is cleared
    wr_mask(8'h02);
    irq_in = 8'h02;
    tick(1);
    irq_in = 8'h00;
    tick(3);
    check("coll_armed_id", 32'(irq_id), 1);
    irq_in = 8'h02;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    enter(32'h6000);
    check("coll_pending_kept", 32'(pending), 32'h02);
    check("coll_svc", 32'(in_service), 1);
    reti();
    tick(1);
    check("coll_retaken_irr", 32'(pc_if.irr), 1);
    check("coll_retaken_id", 32'(irq_id), 1);
    enter(32'h7000);
    check("coll_pending_clear", 32'(pending), 0);
    reti();

    // Asynchronous reset while armed, line held high through release
    wr_mask(8'h01);
    irq_in = 8'h01;
    tick(4);
    check("rst2_armed", 32'(pc_if.irr), 1);
    #1 rstn = 1'b0;
    #1;
    check("rst2_async_irr", 32'(pc_if.irr), 0);
    check("rst2_async_ret", pc_if.irr_ret, 0);
    tick(1);
    check("rst2_pending", 32'(pending), 0);
    check("rst2_svc", 32'(in_service), 0);
    rstn = 1'b1;
    tick(8);
    check("rst2_no_req", 32'(pc_if.irr), 0);
    check("rst2_no_svc", 32'(in_service), 0);
    irq_in = 8'h00;
    tick(2);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
